// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and constants for the divide initiator.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/div_ctrl_sign_fix.sv
// sign_fix: conditional two's-complement negate of a WIDTH-bit value (wraps).
module sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? -mag : mag;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage initiator for the multi-cycle divider; handles stall, sign
// correction, annul draining and local divide-by-zero resolution.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             annul,
    output logic             stall_req,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    state_t state, state_nxt;
    logic q_neg, r_neg;
    logic [WIDTH-1:0] abs_a, abs_b, fix_q, fix_r;
    logic take, b_zero;

    assign take   = req & ~annul;
    assign b_zero = op_b == '0;

    sign_fix #(.WIDTH(WIDTH)) u_abs_a (.mag(op_a),  .neg(signed_op & op_a[WIDTH-1]), .res(abs_a));
    sign_fix #(.WIDTH(WIDTH)) u_abs_b (.mag(op_b),  .neg(signed_op & op_b[WIDTH-1]), .res(abs_b));
    sign_fix #(.WIDTH(WIDTH)) u_fix_q (.mag(div_q), .neg(q_neg),                     .res(fix_q));
    sign_fix #(.WIDTH(WIDTH)) u_fix_r (.mag(div_r), .neg(r_neg),                     .res(fix_r));

    always_comb begin
        state_nxt    = state;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                stall_req = rst & take;
                if (take) state_nxt = b_zero ? DONE : BUSY;
            end
            BUSY: begin
                stall_req = 1'b1;
                if (div_done) state_nxt = annul ? IDLE : DONE;
                else if (annul) state_nxt = DRAIN;
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            DRAIN: begin
                // the divider finishes once started; wait out its stale result
                stall_req = req;
                if (div_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && take) begin
                if (b_zero) begin
                    lo <= DIV0_LO[WIDTH-1:0];
                    hi <= op_a;
                end else begin
                    div_a     <= abs_a;
                    div_b     <= abs_b;
                    q_neg     <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    r_neg     <= signed_op & op_a[WIDTH-1];
                    div_start <= 1'b1;
                end
            end
            if (state == BUSY && (div_done || annul)) div_start <= 1'b0;
            if (state == BUSY && div_done && !annul) begin
                lo <= fix_q;
                hi <= fix_r;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized self-checking bench for div_ctrl with a fixed-latency
// behavioural divider and an arithmetic reference model.
module tb_div_ctrl;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic clk = 1'b0, rst = 1'b1, req = 1'b0, signed_op = 1'b0, annul = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic stall_req, result_valid, div_start, div_done;
    logic [W-1:0] hi, lo, div_a, div_b, div_q, div_r;
    logic dv_busy;
    logic [5:0] dv_cnt;
    logic [W-1:0] dv_a, dv_b;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .annul(annul),
        .stall_req(stall_req), .result_valid(result_valid), .hi(hi), .lo(lo),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_q(div_q), .div_r(div_r)
    );

    // divider: samples operands when idle and started, done LAT cycles after start first seen
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_busy <= 1'b0;
            dv_cnt  <= '0;
            dv_a    <= '0;
            dv_b    <= '0;
        end else if (!dv_busy) begin
            if (div_start) begin
                dv_busy <= 1'b1;
                dv_cnt  <= 6'(LAT - 1);
                dv_a    <= div_a;
                dv_b    <= div_b;
            end
        end else if (dv_cnt == 0) dv_busy <= 1'b0;
        else dv_cnt <= dv_cnt - 6'd1;
    end

    assign div_done = dv_busy && dv_cnt == 0;
    assign div_q    = (dv_b == 0) ? '1 : dv_a / dv_b;
    assign div_r    = (dv_b == 0) ? dv_a : dv_a % dv_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic [W-1:0] ma, output logic [W-1:0] mb);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        ma = W'(sa < 0 ? -sa : sa);
        mb = W'(sb < 0 ? -sb : sb);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] eq, er, ma, mb, ha, hb;
        int rv_at, n_stall, bad_hold, exp_at;
        bit started;
        rv_at = -1; n_stall = 0; bad_hold = 0; started = 0; ha = '0; hb = '0;
        ref_div(a, b, s, eq, er, ma, mb);
        exp_at = (b == 0) ? 1 : LAT + 2;
        req = 1'b1; signed_op = s; op_a = a; op_b = b; annul = 1'b0;
        for (int c = 0; c < 3 * LAT && rv_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("rv_at_request", result_valid, 0);
            if (stall_req) n_stall++;
            if (div_start && !started) begin
                started = 1;
                ha = div_a;
                hb = div_b;
                chk("div_a", div_a, ma);
                chk("div_b", div_b, mb);
            end
            if (started && div_start && {div_a, div_b} !== {ha, hb}) bad_hold++;
            if (result_valid) begin
                rv_at = c;
                chk("lo", lo, eq);
                chk("hi", hi, er);
                chk("stall_in_done", stall_req, 0);
            end
            cyc();
        end
        req = 1'b0;
        chk("rv_cycle", rv_at, exp_at);
        chk("stall_cycles", n_stall, exp_at);
        chk("start_used", started, b != 0);
        chk("operand_hold", bad_hold, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, stall_req, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_start"}, div_start, 0);
        chk({tag, "_div_a"}, div_a, 0);
        chk({tag, "_div_b"}, div_b, 0);
        chk({tag, "_hi"}, hi, 0);
        chk({tag, "_lo"}, lo, 0);
    endtask

    initial begin
        int bad;
        bit got;
        logic [W-1:0] ra, rb;
        #1 rst = 1'b0;
        #1 check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        divide(32'd43, 32'd7, 1'b0);
        divide(32'hFFFF_FFD5, 32'd7, 1'b1);
        divide(32'd43, 32'hFFFF_FFF9, 1'b1);
        divide(32'h1234, 32'd0, 1'b0);
        divide(32'd100, 32'd9, 1'b1);
        divide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // annul five cycles into BUSY, then a new request waits in DRAIN
        req = 1'b1; signed_op = 1'b0; op_a = 32'd43; op_b = 32'd7;
        repeat (6) cyc();
        annul = 1'b1;
        @(negedge clk);
        chk("stall_on_annul", stall_req, 1);
        cyc();
        annul = 1'b0; op_a = 32'd100; op_b = 32'd9;
        bad = 0; got = 0;
        for (int c = 0; c < 3 * LAT && !got; c++) begin
            @(negedge clk);
            if (!stall_req || div_start || result_valid) bad++;
            got = div_done;
            cyc();
        end
        chk("drain_done_seen", got, 1);
        chk("drain_behaviour", bad, 0);
        divide(32'd100, 32'd9, 1'b0);

        // asynchronous reset in the middle of BUSY
        req = 1'b1; signed_op = 1'b0; op_a = 32'd43; op_b = 32'd7;
        repeat (10) cyc();
        rst = 1'b0;
        #1 check_zero("mid_reset");
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        divide(32'd43, 32'd7, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = -W'($urandom_range(1, 15));
                3: begin ra = 32'h8000_0000; rb = '1; end
                default: rb = $urandom;
            endcase
            divide(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

EX-stage initiator for the `div32` multi-cycle divider. It accepts a DIV/DIVU request from the execute stage and holds the pipeline with a stall request. It converts signed operands to magnitudes and drives the divider's start/operand handshake, then sign-corrects the quotient and remainder for HI/LO. Annulled requests are drained safely, and divide-by-zero is resolved locally without invoking the divider.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  one clock; reset is asynchronous and active-low (rst=0 resets).
- `req`  in  1  EX stage holds a divide; held stable while `stall_req`=1.
- `signed_op`  in  1  1=DIV (signed), 0=DIVU.
- `op_a`  in  WIDTH  dividend.
- `op_b`  in  WIDTH  divisor.
- `annul`  in  1  flush of the EX instruction (exception/branch kill).
- `stall_req`  out  1  freeze IF..EX.
- `result_valid`  out  1  one-cycle pulse; `hi`/`lo` valid.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.
- `div_start`  out  1  request to divider; high until `div_done` seen.
- `div_a`, `div_b`  out  WIDTH  unsigned magnitudes to divider, stable while `div_start`=1.
- `div_done`  in  1  one-cycle pulse from divider; `div_q`/`div_r` valid that cycle.
- `div_q`, `div_r`  in  WIDTH  unsigned quotient/remainder.

## Operation
- States: IDLE, BUSY, DONE, DRAIN. Registered state, `div_start`, `div_a`, `div_b`, sign flags, `hi`, `lo`.
- Reset: state=IDLE, all outputs 0.
- IDLE:
  - `stall_req` = `req` & !`annul` (combinational).
  - On `req` & !`annul` & `op_b`==0: `lo`←all ones, `hi`←`op_a`, → DONE.
  - On `req` & !`annul` & `op_b`!=0: latch |`op_a`|, |`op_b`| (abs only when `signed_op`), `q_neg`=`signed_op`&(a[MSB]^b[MSB]), `r_neg`=`signed_op`&a[MSB], `div_start`←1, → BUSY.
- BUSY:
  - `stall_req`=1, `div_start`=1.
  - On `div_done`: `lo`←`q_neg` ? −`div_q` : `div_q`; `hi`←`r_neg` ? −`div_r` : `div_r` (two's complement, WIDTH bits, wrap); `div_start`←0; → DONE.
  - On `annul` without `div_done`: `div_start`←0, → DRAIN.
  - On `annul` with `div_done` in the same cycle: discard the result, → IDLE.
- DONE: `result_valid`=1, `stall_req`=0, `hi`/`lo` hold; EX advances at the end of this cycle; → IDLE unconditionally (`annul` here is ignored by this block; WB squashes).
- DRAIN:
  - `stall_req` = `req` (a new divide waits); `div_start`=0.
  - On `div_done`: discard the result, → IDLE.
  - The divider completes once started regardless of `div_start`.
- `hi`/`lo` hold their last values outside DONE.
- 0x80000000 magnitude is 0x80000000 unsigned (correct).
- Signed 0x80000000/−1 gives `lo`=0x80000000, `hi`=0 by wrap.

## Timing
- Request seen in cycle 0 (IDLE).
- `div_start` first high in cycle 1.
- If `div_done` arrives in cycle k, `result_valid` is high in cycle k+1 and `stall_req` is low that cycle.
- Divide-by-zero: `result_valid` in cycle 1; `stall_req` high only in cycle 0.
- The earliest next request is accepted in cycle k+2.
- Back-to-back divides add one idle cycle.
- `div_start` rises only from IDLE and is never reasserted before the outstanding `div_done`.
- `div_a`/`div_b` are constant between `div_start` rise and `div_done`.
- `rst` low mid-operation: immediate return to IDLE with outputs 0. The divider shares `rst`, so no drain is needed.

## Structure
- A shared package holds the state enum (IDLE/BUSY/DONE/DRAIN) and the `DIV0_LO`=all-ones constant.
- One natural sub-module, `sign_fix`: combinational conditional negate (magnitude in, flag in, result out), instantiated four times (two abs, two fix-up).
- The divider is not instantiated inside this block; top-level wiring connects it.

## Test plan
Bench uses `div32` or a behavioural divider with a fixed 33-cycle latency.
- Unsigned 43/7 -> `lo`=6, `hi`=1, one `result_valid` pulse, `stall_req` high for exactly the cycles from request to `div_done`.
- Signed −43/7 (0xFFFFFFD5/7) -> `lo`=0xFFFFFFFA, `hi`=0xFFFFFFFF; 43/−7 -> `lo`=0xFFFFFFFA, `hi`=1.
- `op_b`=0, `op_a`=0x1234 -> `result_valid` in cycle 1, `lo`=0xFFFFFFFF, `hi`=0x1234, `div_start` never asserted.
- Annul 5 cycles into BUSY, new request next cycle -> no `result_valid` for the first divide; `stall_req` held and `div_start` low until the stale `div_done`; the second divide then completes correctly.
- Two back-to-back divides, 100/9 then 0x80000000/0xFFFFFFFF signed -> (`lo`=11, `hi`=1) then (`lo`=0x80000000, `hi`=0); one idle cycle between them.
- `rst` low in mid-BUSY -> all outputs 0 immediately; after release a fresh 43/7 yields `lo`=6, `hi`=1.
